// File: rtl/hls_key_pkg.sv
// Shared definitions for the key loader in front of the obfuscated MACC core.
// Contents:
//   KEY_W_DEF        default key width
//   key_state_e      loader FSM states
//   WK_RST_BIT       reset value of every working_key bit
package hls_key_pkg;

   localparam int KEY_W_DEF = 4;

   localparam logic WK_RST_BIT = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_CHECK,
      ST_READY,
      ST_ERR
   } key_state_e;

endpackage

// File: rtl/hls_key_shreg.sv
// Serial key assembler: shift register, bit counter and running XOR parity.
// Ports:
//   ap_clk, ap_rst  clock, synchronous active-high reset
//   clr             clears register, counter and parity accumulator
//   shift           accept bit_in this cycle
//   bit_in          serial data, LSB first, parity bit last
//   shreg           assembled key bits
//   at_parity       next accepted bit is the parity bit
//   parity_ok       XOR over key bits plus parity bit is zero
import hls_key_pkg::*;

module hls_key_shreg #(
   parameter int KEY_W = KEY_W_DEF
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic             clr,
   input  logic             shift,
   input  logic             bit_in,
   output logic [KEY_W-1:0] shreg,
   output logic             at_parity,
   output logic             parity_ok
);

   localparam int CNT_W = $clog2(KEY_W + 1);

   logic [CNT_W-1:0] cnt;
   logic             acc;

   assign at_parity = (cnt == CNT_W'(KEY_W));
   // acc folds in the parity bit too, so a clean load leaves it at zero
   assign parity_ok = ~acc;

   always_ff @(posedge ap_clk) begin
      if (ap_rst || clr) begin
         shreg <= '0;
         cnt   <= '0;
         acc   <= 1'b0;
      end else if (shift) begin
         acc <= acc ^ bit_in;
         // counter parks at KEY_W: the parity bit ends the load, no wrap
         if (!at_parity) begin
            shreg <= (shreg >> 1) | (KEY_W'(bit_in) << (KEY_W - 1));
            cnt   <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/hls_key_loader.sv
// Loads the core unlock key from a parity-protected serial stream and gates
// the core start until a checked key has been committed.
// Ports:
//   ap_clk, ap_rst   clock, synchronous active-high reset
//   key_load         one-cycle request to start a new load
//   key_bit          serial key data, LSB first, then one parity bit
//   key_bit_vld      key_bit valid
//   key_bit_rdy      loader accepts key_bit (high only while shifting)
//   working_key      committed key driving the core next-state logic
//   key_ready        working_key holds a parity-checked key
//   key_err          last load failed parity
//   ap_start         host start request
//   core_ap_start    start forwarded to the core, only with a committed key
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | out of reset, no key loaded
// SHIFT | collecting key bits and the parity bit
// CHECK | one cycle, parity evaluated and result committed
// READY | key committed, core may start
// ERR   | parity failure, working_key cleared
import hls_key_pkg::*;

module hls_key_loader #(
   parameter int KEY_W = KEY_W_DEF
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic             key_load,
   input  logic             key_bit,
   input  logic             key_bit_vld,
   output logic             key_bit_rdy,
   output logic [KEY_W-1:0] working_key,
   output logic             key_ready,
   output logic             key_err,
   input  logic             ap_start,
   output logic             core_ap_start
);

   key_state_e       state;
   key_state_e       state_nxt;
   logic             load_go;
   logic             shift_en;
   logic [KEY_W-1:0] shreg;
   logic             at_parity;
   logic             parity_ok;

   // a load request is ignored only while the parity result is in flight
   assign load_go  = key_load && (state != ST_CHECK);
   // key_load takes priority over a bit offered in the same cycle
   assign shift_en = (state == ST_SHIFT) && key_bit_vld && !key_load;

   assign key_bit_rdy   = (state == ST_SHIFT);
   assign core_ap_start = ap_start & key_ready;

   hls_key_shreg #(
      .KEY_W(KEY_W)
   ) u_shreg (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .clr       (load_go),
      .shift     (shift_en),
      .bit_in    (key_bit),
      .shreg     (shreg),
      .at_parity (at_parity),
      .parity_ok (parity_ok)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_READY, ST_ERR: begin
            if (key_load) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (key_load)                   state_nxt = ST_SHIFT;
            else if (shift_en && at_parity) state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            state_nxt = parity_ok ? ST_READY : ST_ERR;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state       <= ST_IDLE;
         working_key <= {KEY_W{WK_RST_BIT}};
         key_ready   <= 1'b0;
         key_err     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load_go) begin
            // working_key holds its old value until the next commit
            key_ready <= 1'b0;
            key_err   <= 1'b0;
         end else if (state == ST_CHECK) begin
            if (parity_ok) begin
               working_key <= shreg;
               key_ready   <= 1'b1;
            end else begin
               working_key <= {KEY_W{WK_RST_BIT}};
               key_err     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hls_key_loader.sv
module tb_hls_key_loader;

   logic       ap_clk = 1'b0;
   logic       ap_rst;
   logic       key_load;
   logic       key_bit;
   logic       key_bit_vld;
   logic       key_bit_rdy;
   logic [3:0] working_key;
   logic       key_ready;
   logic       key_err;
   logic       ap_start;
   logic       core_ap_start;

   int n_cmp = 0;
   int n_bad = 0;

   // reference: what the host should see after each completed load
   logic [3:0] exp_key;
   logic       exp_ready;
   logic       exp_err;

   hls_key_loader #(.KEY_W(4)) dut (
      .ap_clk        (ap_clk),
      .ap_rst        (ap_rst),
      .key_load      (key_load),
      .key_bit       (key_bit),
      .key_bit_vld   (key_bit_vld),
      .key_bit_rdy   (key_bit_rdy),
      .working_key   (working_key),
      .key_ready     (key_ready),
      .key_err       (key_err),
      .ap_start      (ap_start),
      .core_ap_start (core_ap_start)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic model_reset();
      exp_key   = 4'h0;
      exp_ready = 1'b0;
      exp_err   = 1'b0;
   endtask

   task automatic model_start();
      exp_ready = 1'b0;
      exp_err   = 1'b0;
   endtask

   // bits[i] is the i-th serial bit; bits[4] is the parity bit
   task automatic model_finish(input logic [4:0] bits);
      if ((bits[0] ^ bits[1] ^ bits[2] ^ bits[3]) == bits[4]) begin
         exp_key   = bits[3:0];
         exp_ready = 1'b1;
      end else begin
         exp_key = 4'h0;
         exp_err = 1'b1;
      end
   endtask

   task automatic pulse_load();
      key_load = 1'b1;
      step();
      key_load = 1'b0;
      model_start();
   endtask

   // mode 0: vld held high, 1: random bubbles, 2: bubble before every bit
   task automatic send_bits(input logic [4:0] bits, input int mode);
      int guard;
      for (int i = 0; i < 5; i++) begin
         if (mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1)) begin
            key_bit_vld = 1'b0;
            key_bit     = 1'($urandom);
            step();
         end
         key_bit     = bits[i];
         key_bit_vld = 1'b1;
         guard = 0;
         while (!key_bit_rdy && guard < 20) begin
            step();
            guard++;
         end
         if (guard >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rdy_timeout: bit %0d got rdy=0 want rdy=1 within 20 cycles", i);
         end
         step();
      end
      key_bit_vld = 1'b0;
   endtask

   task automatic test_reset();
      ap_rst = 1'b1; key_load = 1'b0; key_bit = 1'b0; key_bit_vld = 1'b0; ap_start = 1'b0;
      step();
      step();
      ap_rst   = 1'b0;
      ap_start = 1'b1;
      model_reset();
      #1;
      n_cmp++; if (working_key !== 4'h0) begin n_bad++; $display("FAIL reset_key: got %h want 0", working_key); end
      n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", key_ready); end
      n_cmp++; if (key_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", key_err); end
      n_cmp++; if (key_bit_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", key_bit_rdy); end
      n_cmp++; if (core_ap_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", core_ap_start); end
      ap_start = 1'b0;
   endtask

   task automatic test_good_load();
      logic [4:0] bits;
      bits = 5'b01010;
      key_load = 1'b1;
      step();
      key_load = 1'b0;
      model_start();
      n_cmp++; if (key_bit_rdy !== 1'b1) begin n_bad++; $display("FAIL good_rdy_after_load: got %b want 1", key_bit_rdy); end
      key_bit_vld = 1'b1;
      for (int i = 0; i < 5; i++) begin
         key_bit = bits[i];
         step();
      end
      key_bit_vld = 1'b0;
      n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL good_ready_at6: got %b want 0", key_ready); end
      n_cmp++; if (key_bit_rdy !== 1'b0) begin n_bad++; $display("FAIL good_rdy_check: got %b want 0", key_bit_rdy); end
      step();
      model_finish(bits);
      n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL good_ready_at7: got %b want 1", key_ready); end
      n_cmp++; if (working_key !== 4'b1010) begin n_bad++; $display("FAIL good_key: got %b want 1010", working_key); end
      n_cmp++; if (working_key !== exp_key) begin n_bad++; $display("FAIL good_key_model: got %b want %b", working_key, exp_key); end
      ap_start = 1'b0; #1;
      n_cmp++; if (core_ap_start !== 1'b0) begin n_bad++; $display("FAIL good_start_lo: got %b want 0", core_ap_start); end
      ap_start = 1'b1; #1;
      n_cmp++; if (core_ap_start !== 1'b1) begin n_bad++; $display("FAIL good_start_hi: got %b want 1", core_ap_start); end
      ap_start = 1'b0;
   endtask

   task automatic test_bad_parity();
      logic [4:0] bits;
      bits = 5'b11010;
      pulse_load();
      send_bits(bits, 0);
      // load request while parity is being evaluated must be ignored
      key_load = 1'b1;
      step();
      key_load = 1'b0;
      model_finish(bits);
      ap_start = 1'b1; #1;
      n_cmp++; if (key_err !== 1'b1) begin n_bad++; $display("FAIL bad_err: got %b want 1", key_err); end
      n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL bad_ready: got %b want 0", key_ready); end
      n_cmp++; if (working_key !== 4'h0) begin n_bad++; $display("FAIL bad_key: got %b want 0000", working_key); end
      n_cmp++; if (core_ap_start !== 1'b0) begin n_bad++; $display("FAIL bad_start: got %b want 0", core_ap_start); end
      n_cmp++; if (key_bit_rdy !== 1'b0) begin n_bad++; $display("FAIL bad_load_in_check: got rdy=%b want 0", key_bit_rdy); end
      ap_start = 1'b0;
   endtask

   task automatic test_restart();
      pulse_load();
      key_bit_vld = 1'b1;
      key_bit = 1'b1; step();
      key_bit = 1'b0; step();
      // restart with a bit offered in the same cycle; that bit must be dropped
      key_load = 1'b1; key_bit = 1'b1;
      step();
      key_load = 1'b0; key_bit_vld = 1'b0;
      model_start();
      n_cmp++; if (key_bit_rdy !== 1'b1) begin n_bad++; $display("FAIL restart_rdy: got %b want 1", key_bit_rdy); end
      send_bits(5'b00011, 0);
      step();
      model_finish(5'b00011);
      n_cmp++; if (working_key !== 4'b0011) begin n_bad++; $display("FAIL restart_key: got %b want 0011", working_key); end
      n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL restart_ready: got %b want 1", key_ready); end
   endtask

   task automatic test_bubbles_reload();
      pulse_load();
      send_bits(5'b01010, 0);
      step();
      model_finish(5'b01010);
      pulse_load();
      n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL reload_ready_drop: got %b want 0", key_ready); end
      n_cmp++; if (working_key !== 4'b1010) begin n_bad++; $display("FAIL reload_key_hold: got %b want 1010", working_key); end
      send_bits(5'b00110, 2);
      step();
      model_finish(5'b00110);
      n_cmp++; if (working_key !== exp_key) begin n_bad++; $display("FAIL bubble_key: got %b want %b", working_key, exp_key); end
      n_cmp++; if (key_ready !== exp_ready) begin n_bad++; $display("FAIL bubble_ready: got %b want %b", key_ready, exp_ready); end
   endtask

   task automatic test_reset_mid_load();
      pulse_load();
      key_bit_vld = 1'b1;
      for (int i = 0; i < 3; i++) begin
         key_bit = 1'($urandom);
         step();
      end
      ap_rst = 1'b1;
      step();
      model_reset();
      n_cmp++; if (key_bit_rdy !== 1'b0) begin n_bad++; $display("FAIL rstmid_rdy: got %b want 0", key_bit_rdy); end
      n_cmp++; if (working_key !== exp_key) begin n_bad++; $display("FAIL rstmid_key: got %b want %b", working_key, exp_key); end
      n_cmp++; if (key_ready !== 1'b0 || key_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_flags: got %b%b want 00", key_ready, key_err); end
      ap_rst = 1'b0;
      step();
      n_cmp++; if (key_bit_rdy !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle_vld: got rdy=%b want 0", key_bit_rdy); end
      key_bit_vld = 1'b0;
   endtask

   task automatic test_random();
      logic [4:0] bits;
      for (int n = 0; n < 24; n++) begin
         bits[3:0] = 4'($urandom);
         bits[4]   = ($urandom_range(0, 3) == 0) ? ~(^bits[3:0]) : (^bits[3:0]);
         pulse_load();
         send_bits(bits, 1);
         step();
         model_finish(bits);
         ap_start = 1'($urandom);
         #1;
         n_cmp++; if (working_key !== exp_key) begin n_bad++; $display("FAIL rand_key[%0d]: got %b want %b", n, working_key, exp_key); end
         n_cmp++; if (key_ready !== exp_ready || key_err !== exp_err) begin n_bad++; $display("FAIL rand_flags[%0d]: got %b%b want %b%b", n, key_ready, key_err, exp_ready, exp_err); end
         n_cmp++; if (core_ap_start !== (ap_start & exp_ready)) begin n_bad++; $display("FAIL rand_start[%0d]: got %b want %b", n, core_ap_start, ap_start & exp_ready); end
         ap_start = 1'b0;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_good_load();
      test_bad_parity();
      test_restart();
      test_bubbles_reload();
      test_reset_mid_load();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hls_key_loader.md
# hls_key_loader

Upstream stage of the FSM-obfuscated MACC core.
- Receives the unlock key as a serial, parity-protected bit stream and assembles it in a shift register.
- On a parity-clean load, commits the key to `working_key`, which drives the core's next-state logic directly.
- Gates the core's `ap_start` until a committed key is present, so the core never runs on a partially loaded key.

## Interface
Parameters:
- `KEY_W`, default 4: key width in bits; matches the core's `working_key` width.

Ports:
- `ap_clk`  in  1: the single clock; all logic is on the rising edge.
- `ap_rst`  in  1: reset, synchronous and active-high; clears all state.
- `key_load`  in  1: one-cycle request to start a new key load.
- `key_bit`  in  1: serial key data, LSB first, followed by one parity bit.
- `key_bit_vld`  in  1: `key_bit` is valid this cycle.
- `key_bit_rdy`  out  1: loader accepts `key_bit` this cycle. A bit transfers when `vld & rdy`.
- `working_key`  out  KEY_W: committed key, fed to the core.
- `key_ready`  out  1: `working_key` holds a parity-checked key.
- `key_err`  out  1: the last load failed its parity check.
- `ap_start`  in  1: start request from the host.
- `core_ap_start`  out  1: start request forwarded to the core.

## Operation
- States:
  - IDLE: after reset.
  - SHIFT: collecting bits.
  - CHECK: one cycle, parity evaluation.
  - READY: key committed.
  - ERR: parity failure.
- Transitions:
  - IDLE, READY or ERR → SHIFT on `key_load`. Entering SHIFT clears the bit counter and the shift register and drops `key_ready` and `key_err`.
  - `working_key` keeps its previous value until the next commit.
  - SHIFT: each accepted bit increments the counter.
  - Bits 0..KEY_W-1 shift into the key register LSB-first; bit index KEY_W is the parity bit.
  - Acceptance of the parity bit moves SHIFT → CHECK.
  - CHECK → READY if the parity bit equals the XOR of the KEY_W key bits. Then `working_key <= shreg` and `key_ready <= 1`.
  - CHECK → ERR otherwise. Then `working_key <= 0` and `key_err <= 1`.
- `key_bit_rdy` = 1 only in SHIFT.
- `core_ap_start` = `ap_start & key_ready`. It is combinational, so there is no added start latency.
- Boundary cases:
  - `key_load` during SHIFT restarts the load: counter and shift register are cleared and the partial key is discarded.
  - `key_load` together with `key_bit_vld` in SHIFT: `key_load` wins and the bit is not accepted.
  - `key_load` during CHECK is ignored.
  - `key_bit_vld` outside SHIFT is ignored; `rdy` is low.
  - `ap_rst` at any point, mid-load included, returns to IDLE on the next edge with all outputs at reset values.
- Counter width: `$clog2(KEY_W+1)`. It never wraps; the parity bit ends SHIFT.

## Timing
- Reset values: `working_key` = 0, `key_ready` = 0, `key_err` = 0, `key_bit_rdy` = 0, `core_ap_start` = 0, state = IDLE.
- `key_load` sampled at edge E: state is SHIFT and `key_bit_rdy` = 1 from the cycle after E.
- Load length: KEY_W+1 accepted bits, with any number of bubbles when `vld` is low.
- Parity bit accepted at edge P: the state is CHECK during the following cycle.
- `working_key`, `key_ready` and `key_err` update at edge P+1. They are visible in the cycle after P+1.
- Minimum load from `key_load` to `key_ready`: KEY_W+3 cycles.
- `key_ready` and `key_err` are never both 1.

## Structure
- Shared package `hls_key_pkg`:
  - state enum (IDLE, SHIFT, CHECK, READY, ERR);
  - default `KEY_W` constant;
  - reset value of `working_key` (all zeros).
- One natural sub-module, `hls_key_shreg`: shift register, bit counter and running XOR parity, with clear/shift/done signals.
- The FSM and output registers stay in `hls_key_loader`.

## Test plan
All cases use KEY_W=4.
- **Reset:** assert `ap_rst` for 2 cycles, then drive `ap_start`=1 → all outputs 0 and `core_ap_start`=0.
- **Good load:** `key_load`, then bits 0,1,0,1 and parity 0 with `vld` held high → `working_key`=4'b1010, `key_ready`=1 seven cycles after `key_load`, and `core_ap_start` follows `ap_start`.
- **Bad parity:** the same key bits with parity 1 → `key_err`=1, `working_key`=0, `key_ready`=0, and `core_ap_start` stays 0.
- **Restart mid-load:** after 2 bits, assert `key_load` together with `key_bit_vld` → that bit is dropped. A following full load of 1,1,0,0 with parity 0 gives `working_key`=4'b0011.
- **Bubbles and reload from READY:**
  - From READY, `key_load` → `key_ready` drops the next cycle while `working_key` holds 4'b1010.
  - Bits with `vld` toggled every other cycle still commit correctly.
- **Reset mid-load:** assert `ap_rst` after 3 bits → state IDLE, `key_bit_rdy`=0, `working_key`=0.
